// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin scheduler sharing one UART transmitter among
//               NUM_REQ requesters. Owns the tx_start/tx_done handshake,
//               acknowledges the captured requester, and aborts a stalled
//               frame with a saturating watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 65536
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          active_o,
  output logic                          tx_start_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_busy_i,
  input  logic                          tx_done_i,
  output logic                          timeout_err_o
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT);

  // Grant pointer after reset: the scan then starts at requester 0.
  localparam logic [GW-1:0]  c_gid_rst = GW'(NUM_REQ - 1);
  // Last watchdog value tolerated before the frame is abandoned.
  localparam logic [WDW-1:0] c_wd_last = WDW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic                   active_q, active_d;
  logic                   tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [WDW-1:0]         wd_q, wd_d;

  logic [GW-1:0]          w_win_idx;
  logic                   w_win_found;
  logic                   w_done_valid;

  // Rotating-priority search: first asserted request after the last grant.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = grant_id_q;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!w_win_found && req_i[(int'(grant_id_q) + off) % NUM_REQ]) begin
        w_win_found = 1'b1;
        w_win_idx   = GW'((int'(grant_id_q) + off) % NUM_REQ);
      end
    end
  end

  // A done pulse coinciding with our own start pulse belongs to an older
  // frame and must not terminate the one just launched.
  assign w_done_valid = tx_done_i && !tx_start_q;

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    ack_d         = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    active_d      = active_q;
    timeout_err_d = 1'b0;
    wd_d          = wd_q;

    case (state_q)
      S_IDLE: begin
        if ((|req_i) && !tx_busy_i && w_win_found) begin
          state_d          = S_WAIT;
          ack_d[w_win_idx] = 1'b1;
          tx_start_d       = 1'b1;
          tx_data_d        = req_data_i[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
          grant_id_d       = w_win_idx;
          active_d         = 1'b1;
          wd_d             = '0;
        end
      end

      S_WAIT: begin
        wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        // Completion has priority over the watchdog on the same cycle.
        if (w_done_valid) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else if (wd_q == c_wd_last) begin
          state_d       = S_IDLE;
          active_d      = 1'b0;
          timeout_err_d = 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      ack_q         <= '0;
      grant_id_q    <= c_gid_rst;
      active_q      <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      grant_id_q    <= grant_id_d;
      active_q      <= active_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      timeout_err_q <= timeout_err_d;
      wd_q          <= wd_d;
    end
  end

  assign ack_o         = ack_q;
  assign grant_id_o    = grant_id_q;
  assign active_o      = active_q;
  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign timeout_err_o = timeout_err_q;

endmodule
`default_nettype wire
